// File: rtl/apb3_csr_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : apb3_csr_bank                                                    |
// | Purpose  : APB3 control/status register bank for the inference core        |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module apb3_csr_bank #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CFG     = 8,
  parameter int NUM_STAT    = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_CFG*DATA_WIDTH-1:0]  cfg_o,
  input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_i,
  input  logic                           busy_i,
  input  logic                           done_i,
  input  logic                           err_i,
  output logic                           start_o,
  output logic                           soft_rst_o,
  output logic                           irq_o
);

  localparam logic [9:0] C_CFG_BASE  = 10'd4;
  localparam logic [9:0] C_STAT_BASE = 10'(4 + NUM_CFG);
  localparam logic [9:0] C_END       = 10'(4 + NUM_CFG + NUM_STAT);
  localparam logic [3:0] C_WAIT      = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t r_state, w_state, w_next;
  logic [3:0] r_wait;
  logic       w_ready, w_load, w_commit, w_viol, w_wr_ok;

  logic [DATA_WIDTH-1:0] r_cfg [NUM_CFG];
  logic r_irq_en, r_done, r_err, r_drop;
  logic r_start, r_soft, r_irq;

  logic [11:0] w_off;
  logic [9:0]  w_idx, w_cfg_sel, w_stat_sel;
  logic        w_is_ctrl, w_is_status, w_is_cfg, w_is_stat, w_map_err;
  logic [DATA_WIDTH-1:0] w_rdata;

  // The setup phase is recognised combinationally from IDLE so that a
  // zero-wait transfer completes in two bus cycles.
  always_comb begin
    w_state = r_state;
    if (r_state == S_IDLE && PSEL && !PENABLE) w_state = S_SETUP;
  end

  always_comb begin
    w_next  = w_state;
    w_ready = 1'b0;
    w_load  = 1'b0;
    case (w_state)
      S_IDLE:  w_next = S_IDLE;
      S_SETUP: begin
        w_next = S_ACCESS;
        w_load = 1'b1;
      end
      S_ACCESS: begin
        if (!PSEL) begin
          w_next = S_IDLE;
        end else if (r_wait == 4'd0) begin
          w_ready = 1'b1;
          w_next  = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_commit = w_ready & PSEL & PENABLE;
  assign w_viol   = rst_n & (w_state == S_IDLE) & PSEL & PENABLE;

  assign w_off      = PADDR[11:0];
  assign w_idx      = w_off[11:2];
  assign w_cfg_sel  = w_idx - C_CFG_BASE;
  assign w_stat_sel = w_idx - C_STAT_BASE;

  assign w_is_ctrl   = (w_idx == 10'd0);
  assign w_is_status = (w_idx == 10'd1);
  assign w_is_cfg    = (w_idx >= C_CFG_BASE) && (w_idx < C_STAT_BASE);
  assign w_is_stat   = (w_idx >= C_STAT_BASE) && (w_idx < C_END);
  assign w_map_err   = (|w_off[1:0])
                     | !(w_is_ctrl | w_is_status | w_is_cfg | w_is_stat)
                     | (PWRITE & w_is_stat);
  assign w_wr_ok     = w_commit & PWRITE & !w_map_err;

  always_comb begin
    w_rdata = '0;
    if (w_is_ctrl)   w_rdata[2]   = r_irq_en;
    if (w_is_status) w_rdata[3:0] = {r_drop, r_err, r_done, busy_i};
    for (int i = 0; i < NUM_CFG; i++) begin
      if (w_is_cfg && w_cfg_sel == 10'(i)) w_rdata = r_cfg[i];
    end
    for (int i = 0; i < NUM_STAT; i++) begin
      if (w_is_stat && w_stat_sel == 10'(i)) w_rdata = stat_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign PRDATA  = (w_commit && !PWRITE && !w_map_err) ? w_rdata : '0;
  assign PSLVERR = (w_commit & w_map_err) | w_viol;
  assign PREADY  = w_ready | w_viol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wait  <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_load)
        r_wait <= C_WAIT;
      else if (w_state == S_ACCESS && r_wait != 4'd0)
        r_wait <= r_wait - 4'd1;
    end
  end

  // Later assignments win: a START refused while busy re-arms START_DROP after
  // a same-write soft reset, and core done/err pulses beat any clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_drop   <= 1'b0;
      r_start  <= 1'b0;
      r_soft   <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_soft  <= 1'b0;
      if (w_wr_ok && w_is_ctrl) begin
        r_irq_en <= PWDATA[2];
        if (PWDATA[1]) begin
          r_soft <= 1'b1;
          r_done <= 1'b0;
          r_err  <= 1'b0;
          r_drop <= 1'b0;
        end
        if (PWDATA[0]) begin
          if (busy_i) r_drop  <= 1'b1;
          else        r_start <= 1'b1;
        end
      end
      if (w_wr_ok && w_is_status) begin
        if (PWDATA[1]) r_done <= 1'b0;
        if (PWDATA[2]) r_err  <= 1'b0;
        if (PWDATA[3]) r_drop <= 1'b0;
      end
      if (done_i) r_done <= 1'b1;
      if (err_i)  r_err  <= 1'b1;
      r_irq <= r_irq_en & (r_done | r_err);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CFG; i++) r_cfg[i] <= '0;
    end else if (w_wr_ok && w_is_cfg) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (w_cfg_sel == 10'(i)) r_cfg[i] <= PWDATA;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
      assign cfg_o[g*DATA_WIDTH +: DATA_WIDTH] = r_cfg[g];
    end
    if (ADDR_WIDTH > 12) begin : g_addr_unused
      logic w_unused_addr;
      assign w_unused_addr = ^PADDR[ADDR_WIDTH-1:12];
    end
  endgenerate

  assign start_o    = r_start;
  assign soft_rst_o = r_soft;
  assign irq_o      = r_irq;

endmodule
`default_nettype wire

// File: doc/apb3_csr_bank.md
# apb3_csr_bank

Parametrised APB3 slave holding the accelerator's control/status register file: configurable counts of RW config and RO status registers, programmable wait states, PSLVERR decoding, start/soft-reset pulses and a level interrupt. Sits between the SoC APB3 bus and the inference core's control path, generalising the bare APB3 interface into a complete CSR block.

## Interface
- ADDR_WIDTH, 32, PADDR width (decode uses PADDR[11:0]; upper bits ignored)
- DATA_WIDTH, 32, bus/register width (≥8)
- NUM_CFG, 8, number of RW config registers (1..248)
- NUM_STAT, 4, number of RO status registers from core (1..248-NUM_CFG)
- WAIT_STATES, 0, PREADY-low cycles inserted in every access phase (0..15)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- PADDR  in  ADDR_WIDTH  APB address
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error
- cfg_o  out  NUM_CFG*DATA_WIDTH  config regs, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
- stat_i  in  NUM_STAT*DATA_WIDTH  core status words
- busy_i  in  1  core busy level
- done_i, err_i  in  1  core completion/error pulses
- start_o, soft_rst_o  out  1  one-cycle pulses to core
- irq_o  out  1  level interrupt

## Operation
- Map (byte offsets, word aligned): 0x000 CTRL; 0x004 STATUS; 0x010+4i CFG[i]; 0x010+4*NUM_CFG+4j STAT[j]; all else unmapped.
- CTRL: bit0 START (W1, reads 0), bit1 SOFT_RST (W1, reads 0), bit2 IRQ_EN (RW). Other bits read 0.
- STATUS: bit0 BUSY (RO, busy_i), bit1 DONE, bit2 ERR, bit3 START_DROP (sticky, W1C). Others 0.
- FSM states IDLE, SETUP, ACCESS. IDLE→SETUP on PSEL&!PENABLE; SETUP→ACCESS next cycle (wait counter loaded with WAIT_STATES); ACCESS→IDLE when PREADY=1; ACCESS with PSEL=0 (aborted) →IDLE, no commit.
- Commit cycle = ACCESS & PSEL & PENABLE & PREADY. Writes take effect at that edge; reads return decoded value combinationally in that cycle.
- PSLVERR=1 at commit for: unmapped address, PADDR[1:0]≠0, write to STAT[j]. Erroring writes change nothing; erroring reads give PRDATA=0.
- Protocol violation (PSEL&PENABLE while IDLE): PREADY=1, PSLVERR=1 that cycle, no commit.
- START write while busy_i=1: start_o suppressed, START_DROP set. Else start_o pulses cycle after commit.
- SOFT_RST write: soft_rst_o pulses cycle after commit; clears DONE/ERR/START_DROP; CFG and IRQ_EN kept.
- done_i/err_i set DONE/ERR; set wins over same-cycle W1C.
- irq_o = registered IRQ_EN & (DONE | ERR).

## Timing
- Reset: PRDATA=0, PREADY=0, PSLVERR=0, cfg_o=0, start_o=0, soft_rst_o=0, irq_o=0, all sticky bits 0, IRQ_EN=0, FSM IDLE. Reset mid-transfer aborts it; no commit.
- PREADY low outside ACCESS; in ACCESS low for WAIT_STATES cycles then high one cycle. WAIT_STATES=0: two-cycle APB transfer.
- PRDATA and PSLVERR are 0 except at commit.
- cfg_o updates at commit edge (visible next cycle). start_o/soft_rst_o exactly one cycle, one cycle after commit.
- STATUS read in the same cycle a done_i arrives returns pre-update value.
- irq_o lags sticky bit/IRQ_EN change by one cycle.
- Back-to-back transfers: commit → SETUP next cycle permitted (IDLE passed implicitly if PSEL&!PENABLE seen).

## Test plan
- Reset, WAIT_STATES=0: write CFG[3]=0xA5A5_0001 at 0x01C, read back → PREADY high in 2nd cycle, PRDATA=0xA5A50001, cfg_o slice 3 matches, PSLVERR=0.
- WAIT_STATES=3: read 0x004 → PREADY low 3 ACCESS cycles then high; write aborted mid-wait (PSEL drop) → no register change.
- Write 0x1 to CTRL with busy_i=0 → start_o one cycle after commit; repeat with busy_i=1 → no pulse, STATUS reads 0x9.
- IRQ_EN=1, pulse done_i → irq_o high one cycle later; W1C 0x2 to STATUS coinciding with new done_i → DONE stays 1; clean W1C → irq_o drops.
- Write 0x3F0 (unmapped), 0x006 (unaligned), STAT[0] address → PSLVERR=1, PRDATA=0, no state change; PENABLE without setup → PSLVERR=1.
- Assert rst_n low during ACCESS → all outputs 0 immediately, cfg_o cleared; SOFT_RST write clears sticky bits, keeps cfg_o.
